// File: rtl/cond_wait_sched.sv
// Condition-wait scheduler: a small shared-variable file plus waiter slots
// that each fire when their predicate holds, drained by a round-robin waker.
module cond_wait_sched #(
  parameter int NVARS = 4,
  parameter int NWAIT = 4,
  parameter int W     = 32,
  localparam int VI   = $clog2(NVARS),
  localparam int SI   = $clog2(NWAIT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [VI-1:0]     wr_idx,
  input  logic [W-1:0]      wr_data,
  input  logic              arm_valid,
  output logic              arm_ready,
  input  logic [SI-1:0]     arm_id,
  input  logic [2:0]        arm_op,
  input  logic [VI-1:0]     arm_a,
  input  logic [VI-1:0]     arm_b,
  input  logic [VI-1:0]     arm_c,
  input  logic              cancel_valid,
  input  logic [SI-1:0]     cancel_id,
  output logic              wake_valid,
  output logic [SI-1:0]     wake_id,
  input  logic              wake_ready,
  output logic [NWAIT-1:0]  pending
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FIRED = 2'd2
  } slot_st_t;

  logic signed [W-1:0] vars [NVARS];
  slot_st_t            st     [NWAIT];
  slot_st_t            st_nxt [NWAIT];
  logic [2:0]          op_r   [NWAIT];
  logic [VI-1:0]       a_r    [NWAIT];
  logic [VI-1:0]       b_r    [NWAIT];
  logic [VI-1:0]       c_r    [NWAIT];
  logic [NWAIT-1:0]    hit;
  logic [SI-1:0]       rr;
  logic                hs;

  // A+B is formed one bit wider than the operands so it can never wrap.
  function automatic logic pred_eval(input logic [2:0] op,
                                     input logic signed [W-1:0] av,
                                     input logic signed [W-1:0] bv,
                                     input logic signed [W-1:0] cv);
    logic signed [W:0] sum;
    logic signed [W:0] c_ext;
    sum   = $signed({av[W-1], av}) + $signed({bv[W-1], bv});
    c_ext = $signed({cv[W-1], cv});
    case (op)
      3'd0:    pred_eval = (av > bv);
      3'd1:    pred_eval = (av < bv);
      3'd2:    pred_eval = (av == bv);
      3'd3:    pred_eval = (av != bv);
      3'd4:    pred_eval = (av >= bv);
      3'd5:    pred_eval = (av <= bv);
      3'd6:    pred_eval = (sum < c_ext);
      default: pred_eval = (av < bv) && (bv > cv);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NVARS; i++) vars[i] <= '0;
    end else if (wr_en) begin
      vars[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NWAIT; i++) begin
      if (st[i] == S_IDLE && arm_valid && arm_id == SI'(i)) begin
        op_r[i] <= arm_op;
        a_r[i]  <= arm_a;
        b_r[i]  <= arm_b;
        c_r[i]  <= arm_c;
      end
    end
  end

  // Predicates see registered variables only, so a same-cycle write is not visible yet.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NWAIT; i++)
      hit[i] = pred_eval(op_r[i], vars[a_r[i]], vars[b_r[i]], vars[c_r[i]]);
  end

  always_comb begin
    logic [SI-1:0] idx;
    idx        = '0;
    wake_valid = 1'b0;
    wake_id    = '0;
    for (int k = 0; k < NWAIT; k++) begin
      idx = rr + SI'(k);
      if (!wake_valid && st[idx] == S_FIRED) begin
        wake_valid = 1'b1;
        wake_id    = idx;
      end
    end
  end

  assign hs        = wake_valid && wake_ready;
  assign arm_ready = (st[arm_id] == S_IDLE);

  always_comb begin
    pending = '0;
    for (int i = 0; i < NWAIT; i++) pending[i] = (st[i] != S_IDLE);
  end

  // Handshake is tested before cancel so a cancel racing the wake is a no-op.
  always_comb begin
    for (int i = 0; i < NWAIT; i++) begin
      st_nxt[i] = st[i];
      case (st[i])
        S_IDLE:
          if (arm_valid && arm_id == SI'(i)) st_nxt[i] = S_ARMED;
        S_ARMED:
          if (cancel_valid && cancel_id == SI'(i)) st_nxt[i] = S_IDLE;
          else if (hit[i])                         st_nxt[i] = S_FIRED;
        S_FIRED:
          if (hs && wake_id == SI'(i))                  st_nxt[i] = S_IDLE;
          else if (cancel_valid && cancel_id == SI'(i)) st_nxt[i] = S_IDLE;
        default:
          st_nxt[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NWAIT; i++) st[i] <= S_IDLE;
      rr <= '0;
    end else begin
      for (int i = 0; i < NWAIT; i++) st[i] <= st_nxt[i];
      if (hs) rr <= wake_id + SI'(1);
    end
  end

endmodule

// File: tb/tb_cond_wait_sched.sv
// Scoreboard bench for cond_wait_sched: a spec-level slot model predicts the
// outputs of every cycle; a monitor process pops and compares them.
module tb_cond_wait_sched;
  localparam int NV = 4;
  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        rst, wr_en, arm_valid, arm_ready, cancel_valid;
  logic        wake_valid, wake_ready;
  logic [1:0]  wr_idx, arm_id, arm_a, arm_b, arm_c, cancel_id, wake_id;
  logic [31:0] wr_data;
  logic [2:0]  arm_op;
  logic [3:0]  pending;

  always #5 clk = ~clk;

  cond_wait_sched #(.NVARS(NV), .NWAIT(NW), .W(32)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .arm_valid(arm_valid), .arm_ready(arm_ready), .arm_id(arm_id), .arm_op(arm_op),
    .arm_a(arm_a), .arm_b(arm_b), .arm_c(arm_c),
    .cancel_valid(cancel_valid), .cancel_id(cancel_id),
    .wake_valid(wake_valid), .wake_id(wake_id), .wake_ready(wake_ready),
    .pending(pending)
  );

  typedef struct {
    bit         wv;
    int         wid;
    logic [3:0] pend;
    bit         ar;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: slot status 0=idle 1=waiting 2=fired, variables as plain numbers.
  logic signed [31:0] mv[NV];
  int ms[NW], mop[NW], ma[NW], mb[NW], mc[NW];
  int mrr;

  function automatic bit mpred(int i);
    longint a, b, c;
    a = mv[ma[i]];
    b = mv[mb[i]];
    c = mv[mc[i]];
    case (mop[i])
      0: return a > b;
      1: return a < b;
      2: return a == b;
      3: return a != b;
      4: return a >= b;
      5: return a <= b;
      6: return (a + b) < c;
      default: return (a < b) && (b > c);
    endcase
  endfunction

  task automatic chk(string nm, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, got, want, $time);
    end
  endtask

  // Called at a falling edge with inputs set: predict this cycle, then advance the model.
  task automatic step();
    exp_t e;
    bit   wv;
    int   wid, idx;
    bit   p[NW];
    wv = 0; wid = 0;
    for (int k = 0; k < NW; k++) begin
      idx = (mrr + k) % NW;
      if (!wv && ms[idx] == 2) begin wv = 1; wid = idx; end
    end
    e.wv = wv; e.wid = wid; e.pend = '0;
    for (int i = 0; i < NW; i++) e.pend[i] = (ms[i] != 0);
    e.ar = (ms[arm_id] == 0);
    sbq.push_back(e);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NV; i++) mv[i] = 0;
      for (int i = 0; i < NW; i++) ms[i] = 0;
      mrr = 0;
    end else begin
      for (int i = 0; i < NW; i++) p[i] = mpred(i);
      for (int i = 0; i < NW; i++) begin
        if (ms[i] == 0) begin
          if (arm_valid && int'(arm_id) == i) begin
            ms[i] = 1; mop[i] = int'(arm_op);
            ma[i] = int'(arm_a); mb[i] = int'(arm_b); mc[i] = int'(arm_c);
          end
        end else if (ms[i] == 1) begin
          if (cancel_valid && int'(cancel_id) == i) ms[i] = 0;
          else if (p[i]) ms[i] = 2;
        end else begin
          if (wv && wake_ready && wid == i) ms[i] = 0;
          else if (cancel_valid && int'(cancel_id) == i) ms[i] = 0;
        end
      end
      if (wr_en) mv[wr_idx] = wr_data;
      if (wv && wake_ready) mrr = (wid + 1) % NW;
    end
    @(negedge clk);
  endtask

  task automatic nop(); step(); endtask

  task automatic wr(int i, int d);
    wr_en = 1; wr_idx = 2'(i); wr_data = d; step(); wr_en = 0;
  endtask

  task automatic arm(int id, int op, int a, int b, int c);
    arm_valid = 1; arm_id = 2'(id); arm_op = 3'(op);
    arm_a = 2'(a); arm_b = 2'(b); arm_c = 2'(c);
    step(); arm_valid = 0;
  endtask

  task automatic cncl(int id);
    cancel_valid = 1; cancel_id = 2'(id); step(); cancel_valid = 0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_wake_valid", int'(wake_valid), int'(e.wv));
        if (e.wv) chk("sb_wake_id", int'(wake_id), e.wid);
        chk("sb_pending", int'(pending), int'(e.pend));
        chk("sb_arm_ready", int'(arm_ready), int'(e.ar));
      end
    end
  end

  initial begin
    rst = 1; wr_en = 0; wr_idx = 0; wr_data = 0; arm_valid = 0; arm_id = 0;
    arm_op = 0; arm_a = 0; arm_b = 0; arm_c = 0; cancel_valid = 0; cancel_id = 0;
    wake_ready = 1;
    for (int i = 0; i < NV; i++) mv[i] = 0;
    for (int i = 0; i < NW; i++) begin ms[i] = 0; mop[i] = 0; ma[i] = 0; mb[i] = 0; mc[i] = 0; end
    mrr = 0;
    @(negedge clk);
    step(); step(); rst = 0;
    chk("rst_wake_valid", int'(wake_valid), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_arm_ready", int'(arm_ready), 1);

    // GT
    arm(0, 0, 0, 1, 0);
    wr(1, 1); nop();
    chk("gt_b_nowake", int'(wake_valid), 0);
    wr(0, 2);
    chk("gt_one_edge", int'(wake_valid), 0);
    nop();
    chk("gt_wake", int'(wake_valid), 1);
    chk("gt_id", int'(wake_id), 0);
    nop();

    // SUM_LT and op7
    wr(0, 2); wr(1, 1);
    arm(1, 6, 0, 1, 2);
    wr(2, 3); nop();
    chk("sum_eq_nowake", int'(wake_valid), 0);
    wr(2, 4); nop();
    chk("sum_wake", int'(wake_valid), 1);
    chk("sum_id", int'(wake_id), 1);
    nop();
    arm(2, 7, 0, 1, 2);
    wr(1, 5); nop();
    chk("and_wake", int'(wake_valid), 1);
    chk("and_id", int'(wake_id), 2);
    nop();

    // Overflow of A+B
    wr(0, 32'h7FFF_FFFF); wr(1, 1); wr(2, 0);
    arm(3, 6, 0, 1, 2); nop();
    chk("ovf_c0", int'(wake_valid), 0);
    wr(2, 32'h7FFF_FFFF); nop();
    chk("ovf_2p31", int'(wake_valid), 0);
    wr(1, 0); nop();
    chk("ovf_equal", int'(wake_valid), 0);
    wr(0, 0); nop();
    chk("ovf_fire", int'(wake_valid), 1);
    chk("ovf_id", int'(wake_id), 3);
    nop();

    // Round-robin
    wake_ready = 0;
    wr(2, 0);
    arm(0, 1, 0, 1, 0); arm(1, 1, 0, 1, 0); arm(3, 1, 0, 1, 0);
    wr(1, 5); nop();
    chk("rr_pending", int'(pending), 4'b1011);
    chk("rr_first", int'(wake_id), 0);
    wake_ready = 1;
    step(); chk("rr_second", int'(wake_id), 1);
    step(); chk("rr_third", int'(wake_id), 3);
    step(); chk("rr_drained", int'(wake_valid), 0);
    wake_ready = 0;
    wr(1, 0);
    arm(0, 1, 0, 1, 0); arm(3, 1, 0, 1, 0);
    wr(1, 5); nop();
    wake_ready = 1;
    chk("rr_wrap_first", int'(wake_id), 0);
    step(); chk("rr_wrap_second", int'(wake_id), 3);
    step(); chk("rr_wrap_drained", int'(wake_valid), 0);

    // Latching and cancel
    wake_ready = 0;
    arm(2, 2, 0, 1, 0);
    wr(1, 0); nop();
    wr(1, 9); nop();
    chk("latch_wake", int'(wake_valid), 1);
    chk("latch_id", int'(wake_id), 2);
    wake_ready = 1; step(); wake_ready = 0;
    chk("latch_taken", int'(wake_valid), 0);
    arm(1, 2, 0, 1, 0);
    cncl(1);
    wr(1, 0); nop();
    chk("cancel_armed_wv", int'(wake_valid), 0);
    chk("cancel_armed_pend", int'(pending), 0);
    arm(1, 2, 0, 1, 0); nop();
    chk("cancel_fired_pre", int'(wake_valid), 1);
    cncl(1);
    chk("cancel_fired_wv", int'(wake_valid), 0);
    chk("cancel_fired_pend", int'(pending), 0);

    // Reset mid-operation
    wr(0, 7);
    arm(0, 3, 0, 1, 0); arm(1, 0, 1, 0, 0); arm(2, 1, 0, 1, 0);
    nop();
    chk("mid_pending", int'(pending), 4'b0111);
    chk("mid_wake", int'(wake_valid), 1);
    rst = 1; step(); rst = 0;
    chk("mid_rst_wv", int'(wake_valid), 0);
    chk("mid_rst_pend", int'(pending), 0);
    arm(3, 2, 0, 1, 0); nop();
    chk("mid_vars_zero", int'(wake_valid), 1);
    chk("mid_vars_id", int'(wake_id), 3);
    wake_ready = 1; nop();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      rst = ($urandom_range(0, 299) == 0);
      wr_en = ($urandom_range(0, 2) == 0);
      wr_idx = 2'($urandom_range(0, 3));
      r = int'($urandom_range(0, 11));
      if (r < 8)       wr_data = 32'($urandom_range(0, 3));
      else if (r == 8) wr_data = 32'h7FFF_FFFF;
      else if (r == 9) wr_data = 32'h8000_0000;
      else             wr_data = 32'hFFFF_FFFF;
      arm_valid = ($urandom_range(0, 1) == 1);
      arm_id = 2'($urandom_range(0, 3));
      arm_op = 3'($urandom_range(0, 7));
      arm_a = 2'($urandom_range(0, 3));
      arm_b = 2'($urandom_range(0, 3));
      arm_c = 2'($urandom_range(0, 3));
      cancel_valid = ($urandom_range(0, 5) == 0);
      cancel_id = 2'($urandom_range(0, 3));
      wake_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    rst = 0; wr_en = 0; arm_valid = 0; cancel_valid = 0; wake_ready = 1;
    nop(); nop();
    repeat (3) @(negedge clk);
    chk("sb_drain", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
